// File: rtl/stack_pkg.sv
// Shared constants for the return-address stack controller:
// size defaults, FSM state codes and stack command encodings.
package stack_pkg;

  localparam int TAM_DEF    = 16;
  localparam int NSTACK_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PUSH = 2'd1;
  localparam logic [1:0] ST_POP  = 2'd2;
  localparam logic [1:0] ST_REC  = 2'd3;

  localparam logic [1:0] CTRL_IDLE = 2'b00;
  localparam logic [1:0] CTRL_PUSH = 2'b01;
  localparam logic [1:0] CTRL_POP  = 2'b10;

  typedef enum logic [1:0] {
    OP_CALL,
    OP_RET,
    OP_IRQ
  } op_e;

endpackage

// File: rtl/stack_depth_cnt.sv
// Saturating occupancy counter for the hardware stack,
// with full/empty decode.
module stack_depth_cnt
  import stack_pkg::*;
#(
  parameter  int NStack = NSTACK_DEF,
  localparam int DW     = $clog2(NStack + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);

  // A push at full overwrites the oldest entry, so depth holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (inc && !full) begin
      depth <= depth + 1'b1;
    end else if (dec && !empty) begin
      depth <= depth - 1'b1;
    end
  end

  assign full  = (depth == DW'(NStack));
  assign empty = (depth == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Call/return stack controller: arbitrates push/pop requests.
// Optional interrupt push port enabled by STACK_CTRL_IRQ_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int TAM    = TAM_DEF,
  parameter int NStack = NSTACK_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         callReq,
  input  logic                         retReq,
`ifdef STACK_CTRL_IRQ_EN
  input  logic                         irqReq,
  output logic                         irqAck,
`endif
  input  logic [TAM-1:0]               PCIn,
  input  logic [2:0]                   flagsIn,
  input  logic                         clrErr,
  output logic [1:0]                   stackCtrl,
  output logic [TAM-1:0]               stackPC,
  output logic [2:0]                   stackFlags,
  output logic                         callAck,
  output logic                         retAck,
  output logic                         busy,
  output logic [$clog2(NStack+1)-1:0]  depth,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] ctrl_d;
  op_e        op_q;
  op_e        op_d;
  logic       ld;
  logic       unf_set;
  logic       ovf_set;
  logic       rec_d;
  logic       irq_go;
  logic [2:0] gnt;

`ifdef STACK_CTRL_IRQ_EN
  assign irq_go = irqReq;
`else
  assign irq_go = 1'b0;
`endif

  assign gnt = {irq_go,
                callReq & ~irq_go,
                retReq & ~callReq & ~irq_go};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl_d  = CTRL_IDLE;
    ld      = 1'b0;
    unf_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          gnt[2]: begin
            state_d = ST_PUSH;
            op_d    = OP_IRQ;
            ctrl_d  = CTRL_PUSH;
            ld      = 1'b1;
          end
          gnt[1]: begin
            state_d = ST_PUSH;
            op_d    = OP_CALL;
            ctrl_d  = CTRL_PUSH;
            ld      = 1'b1;
          end
          gnt[0]: begin
            op_d = OP_RET;
            if (!empty) begin
              state_d = ST_POP;
              ctrl_d  = CTRL_POP;
            end else begin
              state_d = ST_REC;
              unf_set = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_PUSH: state_d = ST_REC;
      ST_POP:  state_d = ST_REC;
      ST_REC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign rec_d   = (state_d == ST_REC);
  assign ovf_set = (state_q == ST_PUSH) && full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CALL;
      stackCtrl  <= CTRL_IDLE;
      stackPC    <= '0;
      stackFlags <= '0;
      callAck    <= 1'b0;
      retAck     <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      stackCtrl <= ctrl_d;
      if (ld) begin
        stackPC    <= PCIn;
        stackFlags <= flagsIn;
      end
      callAck   <= rec_d && (op_d == OP_CALL);
      retAck    <= rec_d && (op_d == OP_RET);
      busy      <= (state_d != ST_IDLE);
      // a new error in the clear cycle takes precedence
      overflow  <= ovf_set | (overflow & ~clrErr);
      underflow <= unf_set | (underflow & ~clrErr);
    end
  end

`ifdef STACK_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      irqAck <= 1'b0;
    end else begin
      irqAck <= rec_d && (op_d == OP_IRQ);
    end
  end
`endif

  stack_depth_cnt #(
    .NStack(NStack)
  ) u_depth (
    .clk  (clk),
    .rst  (rst),
    .inc  (state_q == ST_PUSH),
    .dec  (state_q == ST_POP),
    .depth(depth),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with an ack/push scoreboard.
// Build with STACK_CTRL_IRQ_EN to cover the interrupt port.
module tb_stack_ctrl;

  localparam int TAM = 16;
  localparam int NS  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           callReq;
  logic           retReq;
`ifdef STACK_CTRL_IRQ_EN
  logic           irqReq;
  logic           irqAck;
`endif
  logic [TAM-1:0] PCIn;
  logic [2:0]     flagsIn;
  logic           clrErr;
  logic [1:0]     stackCtrl;
  logic [TAM-1:0] stackPC;
  logic [2:0]     stackFlags;
  logic           callAck;
  logic           retAck;
  logic           busy;
  logic [3:0]     depth;
  logic           full;
  logic           empty;
  logic           overflow;
  logic           underflow;

  stack_ctrl #(.TAM(TAM), .NStack(NS)) dut (
    .clk       (clk),
    .rst       (rst),
    .callReq   (callReq),
    .retReq    (retReq),
`ifdef STACK_CTRL_IRQ_EN
    .irqReq    (irqReq),
    .irqAck    (irqAck),
`endif
    .PCIn      (PCIn),
    .flagsIn   (flagsIn),
    .clrErr    (clrErr),
    .stackCtrl (stackCtrl),
    .stackPC   (stackPC),
    .stackFlags(stackFlags),
    .callAck   (callAck),
    .retAck    (retAck),
    .busy      (busy),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int             checks    = 0;
  int             failures  = 0;
  int             acks_seen = 0;
  int             pops_seen = 0;
  int             exp_ack[$];
  logic [TAM-1:0] exp_pc[$];
  logic [2:0]     exp_fl[$];
  logic [1:0]     prev_ctrl = 2'b00;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic got(int k);
    int e;
    acks_seen++;
    if (exp_ack.size() == 0) e = -1;
    else e = exp_ack.pop_front();
    chk("ack_order", k, e);
  endtask

  function automatic logic pending();
`ifdef STACK_CTRL_IRQ_EN
    return callReq | retReq | irqReq;
`else
    return callReq | retReq;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
    chk("ctrl_onehot", stackCtrl != 2'b11, 1);
    chk("ctrl_gap", (prev_ctrl != 2'b00) && (stackCtrl != 2'b00), 0);
    prev_ctrl = stackCtrl;
    if (stackCtrl == 2'b10) pops_seen++;
    if (stackCtrl == 2'b01) begin
      if (exp_pc.size() == 0) begin
        chk("push_unexpected", 1, 0);
      end else begin
        chk("push_pc", stackPC, exp_pc.pop_front());
        chk("push_flags", stackFlags, exp_fl.pop_front());
      end
    end
`ifdef STACK_CTRL_IRQ_EN
    if (irqAck) begin got(0); irqReq = 1'b0; end
`endif
    if (callAck) begin got(1); callReq = 1'b0; end
    if (retAck) begin got(2); retReq = 1'b0; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || pending()) && n < 100);
    chk("idle_timeout", n < 100, 1);
  endtask

  task automatic exp_push(logic [TAM-1:0] pc, logic [2:0] fl);
    exp_pc.push_back(pc);
    exp_fl.push_back(fl);
  endtask

  task automatic call(logic [TAM-1:0] pc, logic [2:0] fl);
    PCIn    = pc;
    flagsIn = fl;
    callReq = 1'b1;
    exp_ack.push_back(1);
    exp_push(pc, fl);
    wait_idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_ack.delete();
    exp_pc.delete();
    exp_fl.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int pbase;
    rst     = 1'b1;
    callReq = 1'b0;
    retReq  = 1'b0;
`ifdef STACK_CTRL_IRQ_EN
    irqReq  = 1'b0;
`endif
    clrErr  = 1'b0;
    PCIn    = '0;
    flagsIn = '0;
    tick();
    tick();
    chk("rst_ctrl", stackCtrl, 0);
    chk("rst_pc", stackPC, 0);
    chk("rst_flags", stackFlags, 0);
    chk("rst_callack", callAck, 0);
    chk("rst_retack", retAck, 0);
    chk("rst_busy", busy, 0);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst = 1'b0;

    retReq = 1'b1;
    exp_ack.push_back(2);
    tick();
    chk("unf_ack", retAck, 1);
    chk("unf_ctrl", stackCtrl, 0);
    chk("unf_flag", underflow, 1);
    chk("unf_depth", depth, 0);
    wait_idle();
    chk("unf_sticky", underflow, 1);
    clrErr = 1'b1;
    tick();
    clrErr = 1'b0;
    chk("unf_clr", underflow, 0);

    base    = acks_seen;
    PCIn    = 16'h1234;
    flagsIn = 3'b101;
    callReq = 1'b1;
    exp_ack.push_back(1);
    exp_push(16'h1234, 3'b101);
    tick();
    chk("c1_ctrl", stackCtrl, 2'b01);
    chk("c1_pc", stackPC, 16'h1234);
    chk("c1_flags", stackFlags, 3'b101);
    chk("c1_noack", callAck, 0);
    chk("c1_busy", busy, 1);
    PCIn = 16'hdead;
    tick();
    chk("c1_ack", callAck, 1);
    chk("c1_ctrl_off", stackCtrl, 0);
    chk("c1_depth", depth, 1);
    tick();
    chk("c1_idle", busy, 0);
    chk("c1_full", full, 0);

    for (int i = 2; i <= 9; i++) begin
      call(16'(i * 16'h111), 3'(i));
      chk("sat_depth", depth, (i < NS) ? i : NS);
      chk("sat_full", full, (i >= NS) ? 1 : 0);
      chk("sat_ovf", overflow, (i == 9) ? 1 : 0);
    end
    chk("sat_acks", acks_seen - base, 9);

    do_reset();
    chk("rst2_depth", depth, 0);
    chk("rst2_ovf", overflow, 0);
    call(16'h0a0a, 3'b001);
    call(16'h0b0b, 3'b010);
    chk("pair_depth0", depth, 2);
    pbase   = pops_seen;
    PCIn    = 16'h00c3;
    flagsIn = 3'b011;
    callReq = 1'b1;
    retReq  = 1'b1;
    exp_ack.push_back(1);
    exp_ack.push_back(2);
    exp_push(16'h00c3, 3'b011);
    n = 0;
    do begin
      tick();
      n++;
    end while (callReq && n < 20);
    chk("pair_call_first", depth, 3);
    wait_idle();
    chk("pair_depth", depth, 2);
    chk("pair_pops", pops_seen - pbase, 1);

`ifdef STACK_CTRL_IRQ_EN
    PCIn    = 16'h0f0f;
    flagsIn = 3'b110;
    irqReq  = 1'b1;
    callReq = 1'b1;
    retReq  = 1'b1;
    exp_ack.push_back(0);
    exp_ack.push_back(1);
    exp_ack.push_back(2);
    exp_push(16'h0f0f, 3'b110);
    exp_push(16'h0f0f, 3'b110);
    wait_idle();
    chk("irq_depth", depth, 3);
`endif

    PCIn    = 16'h5555;
    flagsIn = 3'b111;
    callReq = 1'b1;
    exp_push(16'h5555, 3'b111);
    tick();
    chk("abort_push", stackCtrl, 2'b01);
    rst = 1'b1;
    tick();
    chk("abort_ctrl", stackCtrl, 0);
    chk("abort_ack", callAck, 0);
    chk("abort_depth", depth, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pc", stackPC, 0);
    callReq = 1'b0;
    rst     = 1'b0;
    tick();
    tick();
    chk("abort_after", callAck, 0);
    chk("abort_idle", busy, 0);
    chk("queue_empty", exp_ack.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
